// File: rtl/robot_maneuver_sequencer.sv
// robot_maneuver_sequencer
//   Converts one-cycle turn states from the navigation FSM into a timed,
//   non-interruptible back-up -> pivot -> settle maneuver, arbitrates the
//   motor driver with a manual requester (valid/ready), and aborts motion
//   when ground contact is lost.
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-high
//   nav_state     0 IDLE, 1 MOVE_FORWARD, 2 TURN_LEFT, 3 TURN_RIGHT
//   ground_detect 1 = wheels on ground
//   manual_valid  manual command request
//   manual_cmd    requested motor command (motor_cmd encoding)
//   manual_ready  combinational grant
//   motor_cmd     registered: 0 STOP, 1 FWD, 2 REV, 3 PIVOT_L, 4 PIVOT_R
//   busy          registered; high in BACKUP, PIVOT, SETTLE, MANUAL
//   maneuver_done registered one-cycle pulse on maneuver completion
//   abort         registered one-cycle pulse on ground-loss termination
module robot_maneuver_sequencer #(
  parameter int unsigned BACKUP_CYCLES = 8,
  parameter int unsigned TURN_CYCLES   = 16,
  parameter int unsigned MANUAL_HOLD   = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] nav_state,
  input  logic       ground_detect,
  input  logic       manual_valid,
  input  logic [2:0] manual_cmd,
  output logic       manual_ready,
  output logic [2:0] motor_cmd,
  output logic       busy,
  output logic       maneuver_done,
  output logic       abort
);

  if (BACKUP_CYCLES < 1) begin : g_bad_backup
    $error("BACKUP_CYCLES must be >= 1");
  end
  if (TURN_CYCLES < 1) begin : g_bad_turn
    $error("TURN_CYCLES must be >= 1");
  end
  if (MANUAL_HOLD < 1) begin : g_bad_hold
    $error("MANUAL_HOLD must be >= 1");
  end
  if ((2 ** CNT_W) <= BACKUP_CYCLES || (2 ** CNT_W) <= TURN_CYCLES ||
      (2 ** CNT_W) <= MANUAL_HOLD) begin : g_bad_cnt_w
    $error("CNT_W too narrow for the configured cycle counts");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_FWD, S_BACKUP, S_PIVOT, S_SETTLE, S_MANUAL
  } state_e;

  typedef enum logic [2:0] {
    M_STOP = 3'd0, M_FWD = 3'd1, M_REV = 3'd2, M_PIVOT_L = 3'd3, M_PIVOT_R = 3'd4
  } cmd_e;

  typedef enum logic [1:0] {
    NAV_IDLE = 2'd0, NAV_FWD = 2'd1, NAV_LEFT = 2'd2, NAV_RIGHT = 2'd3
  } nav_e;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             turn_right;   // 1: maneuver was triggered by TURN_RIGHT
  cmd_e             manual_q;
  cmd_e             motor_q;

  nav_e nav;
  logic turn_req;
  logic decide;
  cmd_e manual_sane;

  assign nav        = nav_e'(nav_state);
  assign turn_req   = (nav == NAV_LEFT) || (nav == NAV_RIGHT);
  assign decide     = (state == S_IDLE) || (state == S_FWD);
  assign manual_sane = (manual_cmd > 3'd4) ? M_STOP : cmd_e'(manual_cmd);

  assign manual_ready = !reset && decide && ground_detect && !turn_req;
  assign motor_cmd    = motor_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      turn_right    <= 1'b0;
      manual_q      <= M_STOP;
      motor_q       <= M_STOP;
      busy          <= 1'b0;
      maneuver_done <= 1'b0;
      abort         <= 1'b0;
    end else begin
      maneuver_done <= 1'b0;
      abort         <= 1'b0;
      unique case (state)
        S_IDLE, S_FWD: begin
          if (!ground_detect) begin
            state   <= S_IDLE;
            motor_q <= M_STOP;
            busy    <= 1'b0;
          end else if (turn_req) begin
            turn_right <= (nav == NAV_RIGHT);
            cnt        <= CNT_W'(BACKUP_CYCLES - 1);
            state      <= S_BACKUP;
            motor_q    <= M_REV;
            busy       <= 1'b1;
          end else if (manual_valid) begin
            manual_q <= manual_sane;
            cnt      <= CNT_W'(MANUAL_HOLD - 1);
            state    <= S_MANUAL;
            motor_q  <= manual_sane;
            busy     <= 1'b1;
          end else if (nav == NAV_FWD) begin
            state   <= S_FWD;
            motor_q <= M_FWD;
            busy    <= 1'b0;
          end else begin
            state   <= S_IDLE;
            motor_q <= M_STOP;
            busy    <= 1'b0;
          end
        end

        S_BACKUP, S_PIVOT, S_MANUAL: begin
          if (!ground_detect) begin
            state   <= S_IDLE;
            motor_q <= M_STOP;
            busy    <= 1'b0;
            abort   <= 1'b1;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (state == S_BACKUP) begin
            cnt     <= CNT_W'(TURN_CYCLES - 1);
            state   <= S_PIVOT;
            // Pivot away from the bump side.
            motor_q <= turn_right ? M_PIVOT_L : M_PIVOT_R;
          end else if (state == S_PIVOT) begin
            state         <= S_SETTLE;
            motor_q       <= M_STOP;
            maneuver_done <= 1'b1;
          end else begin
            // Manual hold expired: resume from nav, turns and manual dropped.
            state   <= (nav == NAV_FWD) ? S_FWD : S_IDLE;
            motor_q <= (nav == NAV_FWD) ? M_FWD : M_STOP;
            busy    <= 1'b0;
          end
        end

        S_SETTLE: begin
          // Settle always completes; turn/manual requests on this edge are dropped.
          if (ground_detect && nav == NAV_FWD) begin
            state   <= S_FWD;
            motor_q <= M_FWD;
          end else begin
            state   <= S_IDLE;
            motor_q <= M_STOP;
          end
          busy <= 1'b0;
        end

        default: begin
          state   <= S_IDLE;
          motor_q <= M_STOP;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_robot_maneuver_sequencer.sv
module tb_robot_maneuver_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] nav_state;
  logic       ground_detect;
  logic       manual_valid;
  logic [2:0] manual_cmd;
  logic       manual_ready;
  logic [2:0] motor_cmd;
  logic       busy;
  logic       maneuver_done;
  logic       abort;

  int errors = 0;
  int checks = 0;

  robot_maneuver_sequencer #(
    .BACKUP_CYCLES(3),
    .TURN_CYCLES  (5),
    .MANUAL_HOLD  (2),
    .CNT_W        (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .nav_state    (nav_state),
    .ground_detect(ground_detect),
    .manual_valid (manual_valid),
    .manual_cmd   (manual_cmd),
    .manual_ready (manual_ready),
    .motor_cmd    (motor_cmd),
    .busy         (busy),
    .maneuver_done(maneuver_done),
    .abort        (abort)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expected per-cycle outputs after a TURN_LEFT from FWD with nav back at 1.
  int turn_mot[10]  = '{2, 2, 2, 4, 4, 4, 4, 4, 0, 1};
  int turn_busy[10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  int turn_done[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
  int simu_mot[10]  = '{2, 2, 2, 3, 3, 3, 3, 3, 0, 1};

  initial begin
    int busy_cnt;
    reset         = 1'b1;
    nav_state     = 2'd1;
    ground_detect = 1'b1;
    manual_valid  = 1'b1;
    manual_cmd    = 3'd1;
    #12;
    check("rst_motor", motor_cmd, 0);
    check("rst_busy", busy, 0);
    check("rst_done", maneuver_done, 0);
    check("rst_abort", abort, 0);
    check("rst_ready", manual_ready, 0);
    manual_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Turn maneuver
    cyc(); check("fwd1", motor_cmd, 1);
    cyc(); check("fwd2", motor_cmd, 1);
    nav_state = 2'd2;
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      nav_state = 2'd1;
      check($sformatf("turn_mot%0d", i), motor_cmd, turn_mot[i]);
      check($sformatf("turn_busy%0d", i), busy, turn_busy[i]);
      check($sformatf("turn_done%0d", i), maneuver_done, turn_done[i]);
      if (busy) busy_cnt++;
    end
    check("turn_busy_len", busy_cnt, 9);

    // Simultaneous turn + manual: turn wins, manual granted after settle
    nav_state    = 2'd3;
    manual_valid = 1'b1;
    manual_cmd   = 3'd1;
    #1;
    check("simu_ready0", manual_ready, 0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      nav_state = 2'd1;
      check($sformatf("simu_mot%0d", i), motor_cmd, simu_mot[i]);
      check($sformatf("simu_ready%0d", i), manual_ready, (i == 9) ? 1 : 0);
    end
    cyc(); manual_valid = 1'b0;
    check("simu_grant_busy", busy, 1);
    check("simu_grant_mot", motor_cmd, 1);
    cyc(); check("simu_hold2_busy", busy, 1);
    cyc(); check("simu_after_busy", busy, 0);
    check("simu_after_mot", motor_cmd, 1);

    // Manual grant from IDLE
    nav_state = 2'd0;
    cyc(); check("idle_mot", motor_cmd, 0);
    manual_valid = 1'b1;
    manual_cmd   = 3'd2;
    #1;
    check("man_ready", manual_ready, 1);
    cyc(); manual_valid = 1'b0;
    check("man_mot1", motor_cmd, 2);
    check("man_busy1", busy, 1);
    cyc(); check("man_mot2", motor_cmd, 2);
    cyc(); check("man_end_mot", motor_cmd, 0);
    check("man_end_busy", busy, 0);
    manual_valid = 1'b1;
    manual_cmd   = 3'd6;
    cyc(); manual_valid = 1'b0;
    check("man6_mot1", motor_cmd, 0);
    check("man6_busy1", busy, 1);
    cyc(); check("man6_busy2", busy, 1);
    cyc(); check("man6_end_busy", busy, 0);

    // Ground loss in the 2nd pivot cycle
    nav_state = 2'd2;
    cyc(); nav_state = 2'd0;
    check("gl_rev", motor_cmd, 2);
    cyc(); cyc();
    cyc(); check("gl_piv1", motor_cmd, 4);
    cyc(); check("gl_piv2", motor_cmd, 4);
    ground_detect = 1'b0;
    cyc();
    check("gl_mot", motor_cmd, 0);
    check("gl_abort", abort, 1);
    check("gl_busy", busy, 0);
    check("gl_done", maneuver_done, 0);
    cyc();
    check("gl_abort_clr", abort, 0);
    ground_detect = 1'b1;

    // Asynchronous reset mid-backup
    nav_state = 2'd3;
    cyc(); nav_state = 2'd1;
    check("ar_rev1", motor_cmd, 2);
    cyc(); check("ar_rev2", motor_cmd, 2);
    #2;
    reset = 1'b1;
    #1;
    check("ar_mot", motor_cmd, 0);
    check("ar_busy", busy, 0);
    check("ar_abort", abort, 0);
    check("ar_done", maneuver_done, 0);
    @(negedge clk);
    reset = 1'b0;
    cyc(); check("ar_fwd", motor_cmd, 1);
    check("ar_fwd_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/robot_maneuver_sequencer.md
# robot_maneuver_sequencer

Timed motion sequencer between the navigation state machine (2-bit state: IDLE/MOVE_FORWARD/TURN_LEFT/TURN_RIGHT) and the wheel motor driver. The navigation FSM holds a turn state for only one cycle. This block converts each turn into a timed, non-interruptible back-up → pivot → settle maneuver. It also shares the motor driver with a manual command requester through a valid/ready handshake, and aborts any motion when ground contact is lost.

## Interface
- BACKUP_CYCLES, 8, cycles of reverse drive per maneuver; must be ≥1, and values <1 cause an elaboration error
- TURN_CYCLES, 16, cycles of pivot drive per maneuver; must be ≥1
- MANUAL_HOLD, 4, cycles a granted manual command is driven; must be ≥1
- CNT_W, 8, phase counter width; must satisfy 2^CNT_W > max(BACKUP_CYCLES, TURN_CYCLES, MANUAL_HOLD)

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- nav_state  in  2  navigation state: 0 IDLE, 1 MOVE_FORWARD, 2 TURN_LEFT, 3 TURN_RIGHT
- ground_detect  in  1  1 = wheels on ground
- manual_valid  in  1  manual command request
- manual_cmd  in  3  requested motor command, same encoding as motor_cmd
- manual_ready  out  1  combinational grant; a transfer occurs when manual_valid && manual_ready
- motor_cmd  out  3  registered motor command: 0 STOP, 1 FWD, 2 REV, 3 PIVOT_L, 4 PIVOT_R
- busy  out  1  registered; 1 in BACKUP, PIVOT, SETTLE or MANUAL
- maneuver_done  out  1  registered one-cycle pulse on completion of a maneuver
- abort  out  1  registered one-cycle pulse when ground loss terminates a maneuver or manual hold

## Operation
- States: S_IDLE, S_FWD, S_BACKUP, S_PIVOT, S_SETTLE, S_MANUAL.
- motor_cmd per state:
  - S_IDLE: STOP
  - S_FWD: FWD
  - S_BACKUP: REV
  - S_PIVOT: PIVOT_R after TURN_LEFT, PIVOT_L after TURN_RIGHT (turn away from the bump side mirrors the nav FSM semantics)
  - S_SETTLE: STOP
  - S_MANUAL: the latched command
- Decisions in S_IDLE/S_FWD use this priority, highest first:
  1. ground_detect=0 → S_IDLE. manual_ready=0.
  2. nav_state TURN_LEFT/TURN_RIGHT → latch the direction bit, load counter with BACKUP_CYCLES-1, go to S_BACKUP. manual_ready=0, so a simultaneous manual request loses.
  3. manual_valid=1 → manual_ready=1. Latch manual_cmd, with values 5–7 latched as STOP. Load counter with MANUAL_HOLD-1 and go to S_MANUAL.
  4. nav_state MOVE_FORWARD → S_FWD. nav_state IDLE → S_IDLE.
- S_BACKUP: decrement the counter each cycle. At 0, load TURN_CYCLES-1 and go to S_PIVOT.
- S_PIVOT: decrement the counter. At 0, go to S_SETTLE.
- S_SETTLE: lasts one cycle. motor_cmd=STOP and maneuver_done=1 during it. Then go to S_IDLE.
- S_MANUAL: decrement the counter. At 0, go to S_IDLE. A new manual request is only accepted from S_IDLE/S_FWD, so a hold ends with at least one STOP or FWD cycle.
- During BACKUP/PIVOT/SETTLE/MANUAL:
  - nav_state is ignored.
  - manual_ready=0.
- Ground loss in any of BACKUP, PIVOT or MANUAL: the next state is S_IDLE, motor_cmd=STOP, and abort pulses with the STOP. maneuver_done does not pulse.
- Ground loss in S_SETTLE: completes normally, with no abort.

## Timing
- Reset (asynchronous, immediate) drives:
  - state S_IDLE
  - counter 0
  - motor_cmd=STOP
  - busy=0, maneuver_done=0, abort=0
- manual_ready is 0 while reset is asserted.
- Latency: an input sampled at edge N changes motor_cmd, busy, maneuver_done and abort after edge N, i.e. during cycle N+1.
- Maneuver length, with no abort:
  - REV for exactly BACKUP_CYCLES cycles
  - PIVOT for exactly TURN_CYCLES cycles
  - STOP for 1 cycle
  - busy=1 for BACKUP_CYCLES+TURN_CYCLES+1 cycles
- A turn request arriving in the same cycle that SETTLE or MANUAL ends is dropped. The nav FSM re-issues it on the next bump.
- Manual grant: motor_cmd equals the latched command for exactly MANUAL_HOLD cycles starting the cycle after the handshake.
- Reset asserted mid-maneuver: STOP immediately, with no maneuver_done or abort pulse.

## Test plan
Parameters for all scenarios: BACKUP_CYCLES=3, TURN_CYCLES=5, MANUAL_HOLD=2.
- Turn maneuver:
  - Stimulus: ground_detect=1, nav_state=1 for 2 cycles, then a 1-cycle TURN_LEFT, then nav_state=1.
  - Required: motor_cmd sequence FWD, REV×3, PIVOT_R×5, STOP×1 with maneuver_done=1, then FWD. busy is high for 9 cycles.
- Simultaneous requests:
  - Stimulus: TURN_RIGHT and manual_valid=1 with manual_cmd=1 in the same cycle.
  - Required: manual_ready=0, REV×3 then PIVOT_L×5. The manual request is granted only after SETTLE.
- Manual grant:
  - Stimulus: manual_valid=1 with manual_cmd=2 in S_IDLE; then manual_cmd=6 after the hold.
  - Required: REV×2, then IDLE/STOP. The second grant drives STOP×2.
- Ground loss:
  - Stimulus: ground_detect drops during the 2nd pivot cycle.
  - Required: next cycle motor_cmd=STOP, abort=1 for one cycle, busy=0, no maneuver_done.
- Asynchronous reset:
  - Stimulus: reset asserted mid-BACKUP, between clock edges.
  - Required: motor_cmd=STOP and busy=0 before the next edge. After release with nav_state=1 → FWD one cycle later.
